// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers for the memories library (sync_fifo and fifo).
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so depths that are not powers of two work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port register-array RAM: synchronous write, asynchronous read.
module ram_sdp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard/FWFT read, almost flags, occupancy count and error pulses.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     W_DATA,
  input  logic                      WEN,
  output logic [DATA_WIDTH-1:0]     R_DATA,
  input  logic                      REN,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic                      ALMOST_FULL,
  output logic                      ALMOST_EMPTY,
  output logic [count_w(DEPTH)-1:0] COUNT,
  output logic                      OVERFLOW,
  output logic                      UNDERFLOW
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = count_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam bit FWFT_MODE = (FWFT == int'(FIFO_FWFT));

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q, count_nxt;
  logic                  full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata, rd_data_q;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return PTR_W'(ptr_inc(32'(p), DEPTH));
  endfunction

  always_comb begin
    wr_acc    = WEN && !full_q;
    rd_acc    = REN && !empty_q;
    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + CNT_W'(1);
    else if (rd_acc && !wr_acc) count_nxt = count_q - CNT_W'(1);
  end

  // Writes in the reset cycle are discarded, so the RAM never sees them.
  ram_sdp #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (CLK),
    .we   (wr_acc && !RST),
    .waddr(wr_ptr),
    .wdata(W_DATA),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
      count_q <= count_nxt;
      // Flags come from the next-state count so they track this cycle's traffic.
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_C);
      ae_q    <= (count_nxt <= AE_C);
      ovf_q   <= WEN && full_q;
      unf_q   <= REN && empty_q;
      if (rd_acc && !FWFT_MODE) rd_data_q <= ram_rdata;
    end
  end

  // FWFT shows the head directly; it is forced to zero while empty so reset reads back 0.
  assign R_DATA       = FWFT_MODE ? (empty_q ? '0 : ram_rdata) : rd_data_q;
  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a standard-mode DEPTH=8 instance and an FWFT DEPTH=5 instance.
module tb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: DEPTH=8, standard read, AF=6, AE=1
  logic       rst_a, wen_a, ren_a;
  logic [7:0] wdata_a, rdata_a;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [3:0] count_a;

  // Instance B: DEPTH=5, FWFT, default thresholds
  logic       rst_b, wen_b, ren_b;
  logic [7:0] wdata_b, rdata_b;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [2:0] count_b;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic       fire_a = 1'b0;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) dut_a (
    .CLK(clk), .RST(rst_a), .W_DATA(wdata_a), .WEN(wen_a), .R_DATA(rdata_a), .REN(ren_a),
    .FULL(full_a), .EMPTY(empty_a), .ALMOST_FULL(af_a), .ALMOST_EMPTY(ae_a),
    .COUNT(count_a), .OVERFLOW(ovf_a), .UNDERFLOW(unf_a)
  );

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) dut_b (
    .CLK(clk), .RST(rst_b), .W_DATA(wdata_b), .WEN(wen_b), .R_DATA(rdata_b), .REN(ren_b),
    .FULL(full_b), .EMPTY(empty_b), .ALMOST_FULL(af_b), .ALMOST_EMPTY(ae_b),
    .COUNT(count_b), .OVERFLOW(ovf_b), .UNDERFLOW(unf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard mode: a read accepted at an edge shows its data after that edge.
  always @(posedge clk) fire_a <= ren_a && !empty_a && !rst_a;

  always @(negedge clk) begin
    if (fire_a) begin
      if (exp_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_rdata: got %0h, expected nothing (queue empty)", rdata_a);
      end else begin
        chk("a_rdata", 32'(rdata_a), 32'(exp_a.pop_front()));
      end
    end
  end

  // FWFT mode: the head on R_DATA is what the pending REN acknowledges.
  always @(negedge clk) begin
    if (!rst_b && ren_b && !empty_b) begin
      if (exp_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_rdata: got %0h, expected nothing (queue empty)", rdata_b);
      end else begin
        chk("b_rdata", 32'(rdata_b), 32'(exp_b.pop_front()));
      end
    end
  end

  task automatic cyc_a(input logic w, input logic [7:0] d, input logic r);
    wen_a = w; wdata_a = d; ren_a = r;
    @(posedge clk); #1;
    wen_a = 1'b0; ren_a = 1'b0;
  endtask

  task automatic cyc_b(input logic w, input logic [7:0] d, input logic r);
    wen_b = w; wdata_b = d; ren_b = r;
    @(posedge clk); #1;
    wen_b = 1'b0; ren_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; wen_a = 1'b0; ren_a = 1'b0; wdata_a = '0;
    rst_b = 1'b1; wen_b = 1'b0; ren_b = 1'b0; wdata_b = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    chk("rst_count", 32'(count_a), 0);
    chk("rst_empty", 32'(empty_a), 1);
    chk("rst_full",  32'(full_a),  0);
    chk("rst_af",    32'(af_a),    0);
    chk("rst_ae",    32'(ae_a),    1);
    chk("rst_rdata", 32'(rdata_a), 0);
    chk("rst_ovf",   32'(ovf_a),   0);
    chk("rst_unf",   32'(unf_a),   0);
    chk("rst_b_empty", 32'(empty_b), 1);
    chk("rst_b_rdata", 32'(rdata_b), 0);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      cyc_a(1'b1, 8'(i), 1'b0);
      exp_a.push_back(8'(i));
      chk("fill_count", 32'(count_a), 32'(i));
      chk("fill_ae",    32'(ae_a),    32'(i <= 1));
      chk("fill_af",    32'(af_a),    32'(i >= 6));
      chk("fill_full",  32'(full_a),  32'(i == 8));
      chk("fill_empty", 32'(empty_a), 0);
    end
    cyc_a(1'b1, 8'h09, 1'b0);
    chk("ovf_pulse", 32'(ovf_a),   1);
    chk("ovf_count", 32'(count_a), 8);
    cyc_a(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", 32'(ovf_a),   0);

    // Drain with REN held
    for (int i = 0; i < 8; i++) cyc_a(1'b0, 8'h00, 1'b1);
    chk("drain_count", 32'(count_a), 0);
    chk("drain_empty", 32'(empty_a), 1);
    chk("drain_ae",    32'(ae_a),    1);
    chk("drain_af",    32'(af_a),    0);
    cyc_a(1'b0, 8'h00, 1'b1);
    chk("unf_pulse", 32'(unf_a),   1);
    chk("unf_hold",  32'(rdata_a), 8'h08);
    cyc_a(1'b0, 8'h00, 1'b0);
    chk("unf_clear", 32'(unf_a),   0);

    // Simultaneous WEN+REN at FULL
    for (int i = 1; i <= 8; i++) begin
      cyc_a(1'b1, 8'(8'h10 + i), 1'b0);
      exp_a.push_back(8'(8'h10 + i));
    end
    chk("full_again", 32'(full_a), 1);
    cyc_a(1'b1, 8'hEE, 1'b1);
    chk("wr_at_full_count", 32'(count_a), 7);
    chk("wr_at_full_ovf",   32'(ovf_a),   1);
    chk("wr_at_full_full",  32'(full_a),  0);
    for (int i = 0; i < 7; i++) cyc_a(1'b0, 8'h00, 1'b1);
    chk("drain2_count", 32'(count_a), 0);

    // Simultaneous WEN+REN at EMPTY
    cyc_a(1'b1, 8'h5A, 1'b1);
    exp_a.push_back(8'h5A);
    chk("rd_at_empty_count", 32'(count_a), 1);
    chk("rd_at_empty_unf",   32'(unf_a),   1);
    cyc_a(1'b0, 8'h00, 1'b1);
    chk("rd_at_empty_data",  32'(rdata_a), 8'h5A);
    chk("rd_at_empty_cnt0",  32'(count_a), 0);

    // Reset with COUNT=5
    for (int i = 1; i <= 5; i++) cyc_a(1'b1, 8'(8'h20 + i), 1'b0);
    chk("pre_rst_count", 32'(count_a), 5);
    rst_a = 1'b1;
    cyc_a(1'b0, 8'h00, 1'b0);
    rst_a = 1'b0;
    chk("mid_rst_count", 32'(count_a), 0);
    chk("mid_rst_empty", 32'(empty_a), 1);
    chk("mid_rst_full",  32'(full_a),  0);
    chk("mid_rst_rdata", 32'(rdata_a), 0);
    cyc_a(1'b1, 8'h3C, 1'b0);
    exp_a.push_back(8'h3C);
    cyc_a(1'b0, 8'h00, 1'b1);
    chk("post_rst_data",  32'(rdata_a), 8'h3C);
    chk("post_rst_count", 32'(count_a), 0);

    // FWFT instance
    cyc_b(1'b1, 8'hA5, 1'b0);
    exp_b.push_back(8'hA5);
    chk("fwft_data",  32'(rdata_b), 8'hA5);
    chk("fwft_empty", 32'(empty_b), 0);
    chk("fwft_count", 32'(count_b), 1);
    for (int k = 0; k < 20; k++) begin
      cyc_b(1'b1, 8'(8'h30 + k), 1'b1);
      exp_b.push_back(8'(8'h30 + k));
      chk("stream_count", 32'(count_b), 1);
    end
    chk("stream_head", 32'(rdata_b), 8'h43);
    cyc_b(1'b0, 8'h00, 1'b1);
    chk("fwft_drain_empty", 32'(empty_b), 1);
    chk("fwft_drain_rdata", 32'(rdata_b), 0);

    cyc_a(1'b0, 8'h00, 1'b0);
    chk("a_queue_left", 32'(exp_a.size()), 0);
    chk("b_queue_left", 32'(exp_b.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
